imem_ctrl: RTL and testbench

IMEM_CTRL -- requirements
Module: imem_ctrl

---
 rtl/imem_pkg.sv | 8 +
 rtl/imem_ctrl_if.sv | 34 +++
 rtl/imem_boot_seq.sv | 32 +++
 rtl/imem_ctrl.sv | 86 ++++++++
 tb/tb_imem_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared defaults and FSM state type for the instruction-memory controller.
package imem_pkg;
    localparam int IMEM_ADDR_W     = 11;
    localparam int IMEM_DATA_W     = 16;
    localparam int IMEM_BOOT_WORDS = 16;

    typedef enum logic [1:0] {S_BOOT, S_IDLE, S_RD_CAP, S_WR_DONE} state_t;
endpackage

// File: rtl/imem_ctrl_if.sv
// imem_ctrl_if: boot-table, CPU fetch, loader write and BSRAM signals of imem_ctrl.
interface imem_ctrl_if import imem_pkg::*; #(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
);
    logic [ADDR_W-1:0] boot_rd_addr;
    logic [DATA_W-1:0] boot_rd_data;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              mem_ce;
    logic              mem_wre;
    logic [ADDR_W-1:0] mem_ad;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              boot_done;
    logic              cpu_hold;

    modport master (
        output boot_rd_addr, fetch_valid, fetch_data, wr_ack,
               mem_ce, mem_wre, mem_ad, mem_din, boot_done, cpu_hold,
        input  boot_rd_data, fetch_req, fetch_addr, wr_req, wr_addr, wr_data, mem_dout
    );
    modport slave (
        input  boot_rd_addr, fetch_valid, fetch_data, wr_ack,
               mem_ce, mem_wre, mem_ad, mem_din, boot_done, cpu_hold,
        output boot_rd_data, fetch_req, fetch_addr, wr_req, wr_addr, wr_data, mem_dout
    );
endinterface

// File: rtl/imem_boot_seq.sv
// imem_boot_seq: boot-copy word counter and completion flag.
module imem_boot_seq import imem_pkg::*; #(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int BOOT_WORDS = IMEM_BOOT_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              last_o,
    output logic              done_o
);
    // Compare at ADDR_W width so BOOT_WORDS = 2**ADDR_W stops at the top address.
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BOOT_WORDS - 1);

    logic [ADDR_W-1:0] cnt_q;
    logic              done_q;

    assign cnt_o  = cnt_q;
    assign last_o = cnt_q == LAST;
    assign done_o = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (en_i) begin
            if (last_o) done_q <= 1'b1;
            else cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: copies the boot table into BSRAM, then arbitrates CPU fetches and loader writes.
module imem_ctrl import imem_pkg::*; #(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int DATA_W     = IMEM_DATA_W,
    parameter int BOOT_WORDS = IMEM_BOOT_WORDS
) (
    input logic         clk,
    input logic         rst_n,
    imem_ctrl_if.master bus
);
    state_t            state_q;
    logic              fetch_valid_q;
    logic              wr_ack_q;
    logic              last_wr_q;
    logic [DATA_W-1:0] fetch_data_q;
    logic [ADDR_W-1:0] boot_cnt;
    logic              boot_last;
    logic              boot_done;
    logic              in_boot;
    logic              rd_pend;
    logic              wr_pend;
    logic              gnt_rd;
    logic              gnt_wr;

    assign in_boot = state_q == S_BOOT;

    imem_boot_seq #(.ADDR_W(ADDR_W), .BOOT_WORDS(BOOT_WORDS)) u_boot (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (in_boot),
        .cnt_o  (boot_cnt),
        .last_o (boot_last),
        .done_o (boot_done)
    );

    // A request seen while its own response pulses is the one just served, not a new one.
    always_comb begin
        rd_pend = bus.fetch_req && !fetch_valid_q;
        wr_pend = bus.wr_req && !wr_ack_q;
        gnt_rd  = state_q == S_IDLE && rd_pend && (!wr_pend || last_wr_q);
        gnt_wr  = state_q == S_IDLE && wr_pend && !gnt_rd;
    end

    assign bus.mem_ce       = rst_n && (in_boot || gnt_rd || gnt_wr);
    assign bus.mem_wre      = rst_n && (in_boot || gnt_wr);
    assign bus.mem_ad       = in_boot ? boot_cnt : gnt_wr ? bus.wr_addr : bus.fetch_addr;
    assign bus.mem_din      = in_boot ? bus.boot_rd_data : bus.wr_data;
    assign bus.boot_rd_addr = boot_cnt;
    assign bus.boot_done    = boot_done;
    assign bus.cpu_hold     = !boot_done;
    assign bus.fetch_valid  = fetch_valid_q;
    assign bus.fetch_data   = fetch_data_q;
    assign bus.wr_ack       = wr_ack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BOOT;
            fetch_valid_q <= 1'b0;
            wr_ack_q      <= 1'b0;
            fetch_data_q  <= '0;
            last_wr_q     <= 1'b1;
        end else begin
            fetch_valid_q <= 1'b0;
            wr_ack_q      <= 1'b0;
            case (state_q)
                S_BOOT: if (boot_last) state_q <= S_IDLE;
                S_IDLE: begin
                    if (gnt_rd) begin
                        state_q   <= S_RD_CAP;
                        last_wr_q <= 1'b0;
                    end else if (gnt_wr) begin
                        state_q   <= S_WR_DONE;
                        wr_ack_q  <= 1'b1;
                        last_wr_q <= 1'b1;
                    end
                end
                S_RD_CAP: begin
                    fetch_data_q  <= bus.mem_dout;
                    fetch_valid_q <= 1'b1;
                    state_q       <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: directed stimulus with a queue-based scoreboard for imem_ctrl.
module tb_imem_ctrl;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int BW = 16;

    typedef struct packed {logic wr; logic [DW-1:0] d;} ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) b ();
    imem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BOOT_WORDS(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.master)
    );

    logic [DW-1:0] mem [0:2**AW-1];
    ev_t ev_q[$];
    logic [AW+DW-1:0] mq[$];
    int cmp = 0;
    int bad = 0;
    int cyc = 0;
    int rd_gnt = 0;
    int wr_gnt = 0;

    function automatic logic [DW-1:0] bw(input logic [AW-1:0] a);
        return 16'hA000 | {5'b0, a};
    endfunction

    assign b.boot_rd_data = bw(b.boot_rd_addr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (b.mem_ce) begin
            if (b.mem_wre) mem[b.mem_ad] <= b.mem_din;
            else b.mem_dout <= mem[b.mem_ad];
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Monitor: every BSRAM write and every fetch_valid/wr_ack pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (b.mem_ce && !b.mem_wre) rd_gnt = cyc;
            if (b.mem_ce && b.mem_wre) begin
                if (b.boot_done) wr_gnt = cyc;
                if (mq.size() == 0) begin
                    cmp++; bad++;
                    $display("FAIL mem_wr_unexpected: got ad %0h din %0h", b.mem_ad, b.mem_din);
                end else chk("mem_wr", 32'({b.mem_ad, b.mem_din}), 32'(mq.pop_front()));
            end
            if (b.fetch_valid || b.wr_ack) begin
                if (ev_q.size() == 0) begin
                    cmp++; bad++;
                    $display("FAIL resp_unexpected: got fetch_valid %0b wr_ack %0b", b.fetch_valid, b.wr_ack);
                end else begin
                    ev_t e;
                    e = ev_q.pop_front();
                    chk("resp_kind", {31'b0, b.wr_ack}, {31'b0, e.wr});
                    if (b.fetch_valid) begin
                        chk("fetch_data", 32'(b.fetch_data), 32'(e.d));
                        chk("fetch_latency", cyc - rd_gnt, 2);
                    end else chk("wr_ack_latency", cyc - wr_gnt, 1);
                end
            end
        end
    end

    task automatic push_boot();
        for (int i = 0; i < BW; i++) mq.push_back({AW'(i), bw(AW'(i))});
    endtask

    task automatic boot_check(input string n);
        for (int i = 0; i < BW; i++) begin
            @(negedge clk);
            chk({n, "_ad"}, 32'(b.mem_ad), i);
            chk({n, "_ce_wre"}, {30'b0, b.mem_ce, b.mem_wre}, 3);
            chk({n, "_done_low"}, {31'b0, b.boot_done}, 0);
        end
        @(negedge clk);
        chk({n, "_done"}, {31'b0, b.boot_done}, 1);
        chk({n, "_cpu_hold"}, {31'b0, b.cpu_hold}, 0);
    endtask

    task automatic drain(input string n);
        int k;
        k = 0;
        while ((ev_q.size() != 0 || mq.size() != 0) && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (ev_q.size() != 0 || mq.size() != 0) begin
            cmp++; bad++;
            $display("FAIL %s: timeout with %0d responses and %0d writes outstanding, required 0", n, ev_q.size(), mq.size());
            ev_q.delete();
            mq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ev_q.push_back('{wr: 1'b0, d: d});
        b.fetch_addr = a;
        b.fetch_req = 1'b1;
        drain("fetch");
        b.fetch_req = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ev_q.push_back('{wr: 1'b1, d: '0});
        mq.push_back({a, d});
        b.wr_addr = a;
        b.wr_data = d;
        b.wr_req = 1'b1;
        drain("write");
        b.wr_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        b.fetch_req = 1'b1;
        b.fetch_addr = 3;
        b.wr_req = 1'b0;
        b.wr_addr = '0;
        b.wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_ce", {31'b0, b.mem_ce}, 0);
        chk("rst_mem_wre", {31'b0, b.mem_wre}, 0);
        chk("rst_fetch_valid", {31'b0, b.fetch_valid}, 0);
        chk("rst_wr_ack", {31'b0, b.wr_ack}, 0);
        chk("rst_boot_done", {31'b0, b.boot_done}, 0);
        chk("rst_cpu_hold", {31'b0, b.cpu_hold}, 1);
        chk("rst_fetch_data", 32'(b.fetch_data), 0);
        // Fetch held through boot must only be served after the copy completes.
        push_boot();
        ev_q.push_back('{wr: 1'b0, d: bw(3)});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        boot_check("boot1");
        drain("fetch_held");
        b.fetch_req = 1'b0;
        do_fetch(15, bw(15));
        do_fetch(0, bw(0));
        do_write(11'h7FF, 16'hBEEF);
        do_fetch(11'h7FF, 16'hBEEF);
        // Last grant was a fetch, so a tie now goes to the write first.
        b.fetch_addr = 11'h7FF;
        b.wr_addr = 11'h7FE;
        b.wr_data = 16'h1111;
        ev_q.push_back('{wr: 1'b1, d: '0});
        ev_q.push_back('{wr: 1'b0, d: 16'hBEEF});
        ev_q.push_back('{wr: 1'b1, d: '0});
        repeat (2) mq.push_back({11'h7FE, 16'h1111});
        b.fetch_req = 1'b1;
        b.wr_req = 1'b1;
        drain("tie_after_fetch");
        b.fetch_req = 1'b0;
        b.wr_req = 1'b0;
        do_fetch(11'h7FE, 16'h1111);
        // Reset while the read is being captured: no fetch_valid, boot restarts at 0.
        b.fetch_addr = 5;
        b.fetch_req = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(b.mem_ce && !b.mem_wre) && k < 20);
        chk("abort_grant_seen", {31'b0, b.mem_ce && !b.mem_wre}, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        b.fetch_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort_fetch_valid", {31'b0, b.fetch_valid}, 0);
            chk("abort_mem_ce", {31'b0, b.mem_ce}, 0);
            chk("abort_boot_done", {31'b0, b.boot_done}, 0);
        end
        // Both ports request from reset release: fetch, write, fetch, write ...
        push_boot();
        for (int i = 0; i < 3; i++) begin
            ev_q.push_back('{wr: 1'b0, d: 16'hBEEF});
            ev_q.push_back('{wr: 1'b1, d: '0});
            mq.push_back({11'h020, 16'h5A5A});
        end
        b.fetch_addr = 11'h7FF;
        b.wr_addr = 11'h020;
        b.wr_data = 16'h5A5A;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        b.fetch_req = 1'b1;
        b.wr_req = 1'b1;
        boot_check("boot2");
        drain("round_robin");
        b.fetch_req = 1'b0;
        b.wr_req = 1'b0;
        do_fetch(11'h020, 16'h5A5A);
        do_fetch(3, bw(3));
        repeat (4) @(negedge clk);
        chk("resp_queue_empty", ev_q.size(), 0);
        chk("write_queue_empty", mq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
